// File: rtl/conv_pkg.sv
// Shared definitions for the convolution / fully-connected inference layers.
//   Q_MAX   : largest requantised output value
//   int8_t  : signed 8-bit feature / weight type
//   state_e : sequencing states of conv_layer_seq
//   requant : ReLU, multiply, arithmetic shift and clamp to 0..Q_MAX
package conv_pkg;

    localparam int Q_MAX = 127;

    typedef logic signed [7:0] int8_t;

    typedef enum logic [1:0] {
        S_BIAS,
        S_LOAD,
        S_MAC,
        S_OUT
    } state_e;

    // pre is taken 64 bits wide so every accumulator width up to 64 fits;
    // the product is formed 96 bits wide, enough for pre * (2^31-1) without
    // wrap, which matches the result of an ACC_W+32 bit computation.
    function automatic logic [7:0] requant(input logic signed [63:0] pre,
                                           input logic [31:0]        q_mult,
                                           input logic [4:0]         q_shift);
        logic signed [95:0] pre_w;
        logic signed [95:0] mult_w;
        logic signed [95:0] prod;
        logic signed [95:0] shifted;
        logic [7:0]         res;
        pre_w   = {{32{pre[63]}}, pre};
        mult_w  = {64'd0, q_mult};
        prod    = pre_w * mult_w;
        shifted = prod >>> q_shift;
        if (pre < 0)
            res = 8'd0;
        else if (shifted > 96'sd127)
            res = 8'(Q_MAX);
        else
            res = shifted[7:0];
        return res;
    endfunction

endpackage

// File: rtl/conv_feat_ram.sv
// Feature-map buffer: IN_CH parallel int8 banks of DEPTH words each.
//   clk     : clock
//   we_i    : write enable, writes all banks at waddr_i
//   waddr_i : raster write address
//   wdata_i : packed channels, ch0 in [7:0]
//   raddr_i : raster read address
//   rdata_o : packed channels read at raddr_i, one cycle after the address
// No reset and a plain registered read so each bank maps onto block RAM.
module conv_feat_ram #(
    parameter int IN_CH = 6,
    parameter int DEPTH = 144,
    parameter int AW    = 8
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [IN_CH*8-1:0]  wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [IN_CH*8-1:0]  rdata_o
);

    for (genvar c = 0; c < IN_CH; c++) begin : g_bank
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i)
                mem_q[waddr_i] <= wdata_i[c*8 +: 8];
            rd_q <= mem_q[raddr_i];
        end

        assign rdata_o[c*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/conv_layer_seq.sv
// Sequential single-MAC valid KxK convolution layer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input pixel handshake, in_data = IN_CH int8 (ch0 low)
//   out_valid/out_ready   : output pixel handshake, out_data = OUT_CH int8 (ch0 low)
//   out_last              : last output pixel of the frame
//   w_addr/w_data         : weight ROM, 1-cycle read latency
//   b_addr/b_data         : bias ROM, 1-cycle read latency
//   busy                  : high whenever not waiting for input
// Flow: load biases once after reset, buffer a whole frame, then for each
// output pixel run every output channel through the MAC (2 cycles per tap)
// and present the packed pixel until it is accepted.
module conv_layer_seq
    import conv_pkg::*;
#(
    parameter int          IN_CH   = 6,
    parameter int          OUT_CH  = 16,
    parameter int          IN_W    = 12,
    parameter int          IN_H    = 12,
    parameter int          K       = 5,
    parameter int          ACC_W   = 32,
    parameter int unsigned Q_MULT  = 1,
    parameter int          Q_SHIFT = 0,
    localparam int TAPS = IN_CH*K*K,
    localparam int WA_W = $clog2(OUT_CH*TAPS),
    localparam int BA_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_CH*8-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_CH*8-1:0]  out_data,
    output logic                 out_last,
    output logic [WA_W-1:0]      w_addr,
    input  logic [7:0]           w_data,
    output logic [BA_W-1:0]      b_addr,
    input  logic [ACC_W-1:0]     b_data,
    output logic                 busy
);

    localparam int OW     = IN_W - K + 1;
    localparam int OH     = IN_H - K + 1;
    localparam int NFEAT  = IN_W*IN_H;
    localparam int FA_W   = $clog2(NFEAT);
    localparam int X_W    = $clog2(IN_W + 1);
    localparam int Y_W    = $clog2(IN_H + 1);
    localparam int IC_W   = $clog2(IN_CH + 1);
    localparam int OC_W   = $clog2(OUT_CH + 1);

    state_e                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic [BA_W-1:0]         b_addr_q;
    logic [OC_W-1:0]         bcnt_q;
    logic [FA_W-1:0]         ld_addr_q;
    logic [X_W-1:0]          ox_q;
    logic [Y_W-1:0]          oy_q;
    logic [X_W-1:0]          kx_q;
    logic [Y_W-1:0]          ky_q;
    logic [IC_W-1:0]         ic_q;
    logic [OC_W-1:0]         oc_q;
    logic                    phase_q;   // 0: address phase, 1: accumulate phase
    logic [WA_W-1:0]         w_addr_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] bias_q [OUT_CH];
    logic [7:0]              out_buf_q [OUT_CH];

    logic                    ram_we;
    logic [FA_W-1:0]         rd_addr;
    logic [IN_CH*8-1:0]      rd_data;
    int8_t                   feat;
    int8_t                   w_s;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] pre;
    logic                    last_tap;
    logic                    last_pix;

    assign ram_we  = (state_q == S_LOAD) && in_valid && in_ready_q;
    assign rd_addr = FA_W'((int'(oy_q) + int'(ky_q)) * IN_W + int'(ox_q) + int'(kx_q));

    conv_feat_ram #(
        .IN_CH (IN_CH),
        .DEPTH (NFEAT),
        .AW    (FA_W)
    ) u_feat_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ld_addr_q),
        .wdata_i (in_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // RAM data and w_data both belong to the address phase just finished,
    // and ic_q has not moved yet, so the channel select lines up.
    assign feat     = rd_data[int'(ic_q)*8 +: 8];
    assign w_s      = w_data;
    assign prod     = feat * w_s;
    assign acc_sum  = acc_q + {{(ACC_W-16){prod[15]}}, prod};
    assign pre      = acc_sum + bias_q[oc_q];
    assign last_tap = (kx_q == X_W'(K-1)) && (ky_q == Y_W'(K-1)) && (ic_q == IC_W'(IN_CH-1));
    assign last_pix = (ox_q == X_W'(OW-1)) && (oy_q == Y_W'(OH-1));

    // Bias table has no reset: it is always refilled in S_BIAS before use.
    // Data for address n arrives while bcnt_q == n+1.
    always_ff @(posedge clk) begin
        if (state_q == S_BIAS && bcnt_q != '0)
            bias_q[bcnt_q - OC_W'(1)] <= b_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BIAS;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            b_addr_q    <= '0;
            bcnt_q      <= '0;
            ld_addr_q   <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            ic_q        <= '0;
            oc_q        <= '0;
            phase_q     <= 1'b0;
            w_addr_q    <= '0;
            acc_q       <= '0;
            for (int i = 0; i < OUT_CH; i++)
                out_buf_q[i] <= '0;
        end else begin
            case (state_q)
                S_BIAS: begin
                    if (bcnt_q == OC_W'(OUT_CH)) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        bcnt_q     <= '0;
                        b_addr_q   <= '0;
                    end else begin
                        bcnt_q <= bcnt_q + OC_W'(1);
                        if (b_addr_q != BA_W'(OUT_CH-1))
                            b_addr_q <= b_addr_q + BA_W'(1);
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        if (ld_addr_q == FA_W'(NFEAT-1)) begin
                            ld_addr_q  <= '0;
                            state_q    <= S_MAC;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            ld_addr_q <= ld_addr_q + FA_W'(1);
                        end
                    end
                end

                S_MAC: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (last_tap) begin
                            out_buf_q[oc_q] <= requant(64'(pre), 32'(Q_MULT), 5'(Q_SHIFT));
                            acc_q <= '0;
                            kx_q  <= '0;
                            ky_q  <= '0;
                            ic_q  <= '0;
                            if (oc_q == OC_W'(OUT_CH-1)) begin
                                oc_q        <= '0;
                                w_addr_q    <= '0;
                                state_q     <= S_OUT;
                                out_valid_q <= 1'b1;
                                out_last_q  <= last_pix;
                            end else begin
                                oc_q     <= oc_q + OC_W'(1);
                                w_addr_q <= w_addr_q + WA_W'(1);
                            end
                        end else begin
                            acc_q    <= acc_sum;
                            // Weight layout follows tap order, so the
                            // address is a plain running count.
                            w_addr_q <= w_addr_q + WA_W'(1);
                            if (kx_q == X_W'(K-1)) begin
                                kx_q <= '0;
                                if (ky_q == Y_W'(K-1)) begin
                                    ky_q <= '0;
                                    ic_q <= ic_q + IC_W'(1);
                                end else begin
                                    ky_q <= ky_q + Y_W'(1);
                                end
                            end else begin
                                kx_q <= kx_q + X_W'(1);
                            end
                        end
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (last_pix) begin
                            ox_q       <= '0;
                            oy_q       <= '0;
                            state_q    <= S_LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= S_MAC;
                            if (ox_q == X_W'(OW-1)) begin
                                ox_q <= '0;
                                oy_q <= oy_q + Y_W'(1);
                            end else begin
                                ox_q <= ox_q + X_W'(1);
                            end
                        end
                    end
                end

                default: state_q <= S_BIAS;
            endcase
        end
    end

    for (genvar i = 0; i < OUT_CH; i++) begin : g_out
        assign out_data[i*8 +: 8] = out_buf_q[i];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
module tb_conv_layer_seq;

    localparam int IN_CH  = 2;
    localparam int OUT_CH = 3;
    localparam int IN_W   = 5;
    localparam int IN_H   = 4;
    localparam int K      = 3;
    localparam int ACC_W  = 32;
    localparam int QM     = 3;
    localparam int QS     = 9;
    localparam int OW     = IN_W - K + 1;
    localparam int OH     = IN_H - K + 1;
    localparam int NPIX   = OW*OH;
    localparam int NB     = IN_W*IN_H;
    localparam int TAPS   = IN_CH*K*K;
    localparam int NW     = OUT_CH*TAPS;
    localparam int MACC   = OUT_CH*2*TAPS;
    localparam int WA_W   = $clog2(NW);
    localparam int BA_W   = $clog2(OUT_CH);
    localparam int DW     = OUT_CH*8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [IN_CH*8-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic [WA_W-1:0]     w_addr;
    logic [7:0]          w_data;
    logic [BA_W-1:0]     b_addr;
    logic [ACC_W-1:0]    b_data;
    logic                busy;

    logic signed [7:0]   fm [IN_CH][IN_H][IN_W];
    logic signed [7:0]   wrom [NW];
    logic signed [31:0]  brom [OUT_CH];
    logic [DW-1:0]       exp_pix [NPIX];

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int t_last_in = 0;

    conv_layer_seq #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .IN_W(IN_W), .IN_H(IN_H), .K(K),
        .ACC_W(ACC_W), .Q_MULT(QM), .Q_SHIFT(QS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last),
        .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) cyc_n <= cyc_n + 1;

    // ROM models with one cycle of read latency
    always @(posedge clk) begin
        w_data <= wrom[w_addr];
        b_data <= brom[b_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int ref_q(input longint pre);
        longint r;
        if (pre < 0) return 0;
        r = (pre * QM) >>> QS;
        if (r > 127) return 127;
        return int'(r);
    endfunction

    task automatic build_expected();
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++)
                for (int oc = 0; oc < OUT_CH; oc++) begin
                    longint acc = 0;
                    for (int ic = 0; ic < IN_CH; ic++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++)
                                acc += longint'(fm[ic][oy+ky][ox+kx]) *
                                       longint'(wrom[oc*TAPS + ic*K*K + ky*K + kx]);
                    exp_pix[oy*OW+ox][oc*8 +: 8] = 8'(ref_q(acc + longint'(brom[oc])));
                end
    endtask

    task automatic fill_const(input int fv, input int wv);
        for (int c = 0; c < IN_CH; c++)
            for (int y = 0; y < IN_H; y++)
                for (int x = 0; x < IN_W; x++)
                    fm[c][y][x] = 8'(fv);
        for (int i = 0; i < NW; i++) wrom[i] = 8'(wv);
    endtask

    task automatic fill_random();
        for (int c = 0; c < IN_CH; c++)
            for (int y = 0; y < IN_H; y++)
                for (int x = 0; x < IN_W; x++)
                    fm[c][y][x] = 8'($urandom);
        for (int i = 0; i < NW; i++) wrom[i] = 8'($urandom);
    endtask

    // Release reset at a falling edge and count cycles until in_ready.
    // in_valid is held high with junk meanwhile; it must not be consumed.
    task automatic release_and_time();
        int k = 0;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = '1;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
            if (!in_ready) check("no_out_in_bias", out_valid, 0);
        end
        in_valid = 1'b0;
        check("in_ready_rise", k, OUT_CH+1);
    endtask

    task automatic feed_frame(input bit bubbles);
        int idx = 0;
        int guard = 0;
        while (idx < NB && guard < 2000) begin
            @(negedge clk);
            guard++;
            check("no_out_while_loading", out_valid, 0);
            in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            for (int c = 0; c < IN_CH; c++)
                in_data[c*8 +: 8] = fm[c][idx / IN_W][idx % IN_W];
            if (in_valid && in_ready) begin
                if (idx == NB-1) t_last_in = cyc_n;
                idx++;
            end
        end
        check("feed_done", idx, NB);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_after_load", in_ready, 0);
        check("busy_after_load", busy, 1);
    endtask

    // mode 0: ready tied high, latency checked; 1: random ready;
    // 2: ready held low for 10 cycles on the second pixel
    task automatic collect_frame(input int mode);
        int idx = 0;
        int stall = 0;
        int guard = 0;
        int last_hs = 0;
        bit pend = 1'b0;
        logic [DW-1:0] pend_data = '0;
        logic [DW-1:0] held = '0;
        while (idx < NPIX && guard < 5000) begin
            @(negedge clk);
            guard++;
            out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (pend) begin
                check("valid_held", out_valid, 1);
                check("data_held", out_data, pend_data);
            end
            if (mode == 2 && idx == 1 && (stall > 0 || out_valid) && stall < 10) begin
                out_ready = 1'b0;
                if (stall == 0) held = out_data;
                else begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, held);
                end
                stall++;
            end
            if (out_valid) check("in_ready_low_in_out", in_ready, 0);
            pend = out_valid && !out_ready;
            pend_data = out_data;
            if (out_valid && out_ready) begin
                check("pix_data", out_data, exp_pix[idx]);
                check("pix_last", out_last, idx == NPIX-1);
                if (mode == 0)
                    check("pix_latency", cyc_n - ((idx == 0) ? t_last_in : last_hs), MACC+1);
                last_hs = cyc_n;
                idx++;
            end
        end
        check("collect_done", idx, NPIX);
        @(negedge clk);
        check("in_ready_after_frame", in_ready, 1);
        check("busy_after_frame", busy, 0);
        check("valid_after_frame", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        fill_const(8, 8);
        for (int i = 0; i < OUT_CH; i++) brom[i] = 0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_busy", busy, 1);

        release_and_time();

        // constant frame with output stall on pixel 2
        build_expected();
        feed_frame(1'b0);
        collect_frame(2);

        // random frame, input bubbles, ready high
        fill_random();
        build_expected();
        feed_frame(1'b1);
        collect_frame(0);

        // random frame, random backpressure
        fill_random();
        build_expected();
        feed_frame(1'b0);
        collect_frame(1);

        // abort in the middle of MAC, reload new biases, rerun
        fill_random();
        feed_frame(1'b0);
        repeat (50) @(negedge clk);
        check("mid_mac_busy", busy, 1);
        check("mid_mac_no_valid", out_valid, 0);
        rst_n = 1'b0;
        brom[0] = int'($urandom_range(0, 8000)) - 4000;
        brom[1] = -100000;
        brom[2] = int'($urandom_range(0, 8000)) - 4000;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 1);
        @(negedge clk);
        release_and_time();
        build_expected();
        feed_frame(1'b1);
        collect_frame(1);

        // saturation: large positive sums
        fill_const(127, 127);
        build_expected();
        feed_frame(1'b0);
        collect_frame(0);

        // strongly negative sums clip to zero
        fill_const(-128, 127);
        build_expected();
        feed_frame(1'b0);
        collect_frame(0);

        // another random frame under the reloaded biases
        fill_random();
        build_expected();
        feed_frame(1'b1);
        collect_frame(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
